// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encodings and constants for the PLL lock supervisor
package pll_sup_pkg;

  // Supervisor state encodings (2-bit, also exported on the debug port)
  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;

  // Width of the lock-loss counter
  localparam int LOSS_W = 8;

  // Saturating increment used by the lock-loss counter
  function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchroniser, flops reset to 0
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second gives a clean level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock timeout retry, lock-loss tracking
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 4096,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 17
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked_async,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic              domain_rst,
  output logic              ready,
  output logic              fault,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        state_o
);

  localparam int     RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam longint CNT_MAX = (longint'(1) <<< CNT_W) - 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  // Reject parameter sets the shared counter or the state machine cannot honour
  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || SETTLE_CYCLES < 1 || MAX_RETRIES < 1) begin : g_bad_range
    $error("pll_lock_supervisor: count parameter below its minimum");
  end
  if ((longint'(RST_CYCLES) - 1) > CNT_MAX || (longint'(LOCK_TIMEOUT) - 1) > CNT_MAX ||
      (longint'(SETTLE_CYCLES) - 1) > CNT_MAX) begin : g_bad_width
    $error("pll_lock_supervisor: CNT_W too narrow for the configured counts");
  end

  logic                locked_s;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [RETRY_W-1:0]  retry_inc;
  logic                fault_q, fault_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked_async),
    .q_o   (locked_s)
  );

  // The counter holds at all-ones so a long RUN never wraps it back into a match
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

  // Next-state logic for the sequencer, counter, retry/fault tracking and loss counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    fault_d = fault_q;
    loss_d  = loss_q;

    if (relock_req) begin
      // Forced relock wins over everything; a lock drop seen in RUN on the same edge still counts once
      state_d = HOLD;
      cnt_d   = '0;
      if (state_q == RUN && !locked_s) begin
        loss_d = loss_sat_inc(loss_q);
      end
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        WAIT: begin
          if (locked_s) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = retry_inc;
            if (retry_inc == RETRY_MAX) begin
              fault_d = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            // A lock glitch while settling is neither a loss nor a retry; just wait again
            state_d = WAIT;
            cnt_d   = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            loss_d  = loss_sat_inc(loss_q);
          end
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      fault_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      loss_q  <= loss_d;
    end
  end

  assign pll_rst    = (state_q == HOLD);
  assign domain_rst = (state_q != RUN);
  assign ready      = (state_q == RUN);
  assign fault      = fault_q;
  assign loss_count = loss_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 8;

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  typedef struct {
    int         at;
    logic [1:0] st;
    logic       fault;
    logic [7:0] loss;
  } exp_t;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked_async;
  logic       relock_req;
  logic       pll_rst;
  logic       domain_rst;
  logic       ready;
  logic       fault;
  logic [7:0] loss_count;
  logic [1:0] state_o;

  exp_t       sb[$];
  logic [7:0] lq[$];
  int         cyc;
  int         checks;
  int         failures;
  logic [7:0] exp_loss;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked_async (locked_async),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .fault        (fault),
    .loss_count   (loss_count),
    .state_o      (state_o)
  );

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input int at, input logic [1:0] st, input logic f, input logic [7:0] l);
    exp_t e;
    e.at = at; e.st = st; e.fault = f; e.loss = l;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; locked_async = 1'b0; relock_req = 1'b0;
    repeat (3) step();
    checks++; if (state_o !== S_HOLD) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_HOLD); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (domain_rst !== 1'b1) begin failures++; $display("FAIL reset_domain_rst got=%b exp=1", domain_rst); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (loss_count !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", loss_count); end
    cyc = 0;
    exp_loss = 8'd0;
    rst = 1'b0;
  endtask

  // Origin: the last reset edge leaves HOLD with cnt=0. locked_async is raised after edge 10
  // so the synchroniser first samples it on edge 11; SETTLE shows after edge 13, RUN 8 later.
  task automatic test_power_up();
    exp_t e;
    for (int k = 1; k <= 25; k++) begin
      if (k < RST_CYCLES)       push_exp(k, S_HOLD, 1'b0, 8'd0);
      else if (k < 13)          push_exp(k, S_WAIT, 1'b0, 8'd0);
      else if (k < 13 + SETTLE_CYCLES) push_exp(k, S_SETTLE, 1'b0, 8'd0);
      else                      push_exp(k, S_RUN, 1'b0, 8'd0);
    end
    for (int k = 1; k <= 25; k++) begin
      step();
      if (cyc == 10) locked_async = 1'b1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st || pll_rst !== (e.st == S_HOLD) || domain_rst !== (e.st != S_RUN) ||
            ready !== (e.st == S_RUN) || fault !== e.fault || loss_count !== e.loss) begin
          failures++;
          $display("FAIL power_up cyc=%0d got st=%0d pll_rst=%b domain_rst=%b ready=%b fault=%b loss=%0d exp st=%0d fault=%b loss=%0d",
                   cyc, state_o, pll_rst, domain_rst, ready, fault, loss_count, e.st, e.fault, e.loss);
        end
      end
    end
    if (sb.size() != 0) begin checks++; failures++; $display("FAIL power_up_leftover got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  // From RUN: relock, then a one-cycle lock drop while SETTLE cnt=5 sends it back to WAIT.
  task automatic test_settle_glitch();
    exp_t e;
    int   b;
    b = cyc;
    for (int k = 1; k <= 24; k++) begin
      if (k <= 4)       push_exp(b + k, S_HOLD, 1'b0, exp_loss);
      else if (k == 5)  push_exp(b + k, S_WAIT, 1'b0, exp_loss);
      else if (k <= 13) push_exp(b + k, S_SETTLE, 1'b0, exp_loss);
      else if (k == 14) push_exp(b + k, S_WAIT, 1'b0, exp_loss);
      else if (k <= 22) push_exp(b + k, S_SETTLE, 1'b0, exp_loss);
      else              push_exp(b + k, S_RUN, 1'b0, exp_loss);
    end
    relock_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1)  relock_req = 1'b0;
      if (k == 11) locked_async = 1'b0;
      if (k == 12) locked_async = 1'b1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st || pll_rst !== (e.st == S_HOLD) || domain_rst !== (e.st != S_RUN) ||
            ready !== (e.st == S_RUN) || fault !== e.fault || loss_count !== e.loss) begin
          failures++;
          $display("FAIL settle_glitch cyc=%0d got st=%0d pll_rst=%b domain_rst=%b ready=%b fault=%b loss=%0d exp st=%0d fault=%b loss=%0d",
                   cyc, state_o, pll_rst, domain_rst, ready, fault, loss_count, e.st, e.fault, e.loss);
        end
      end
    end
    if (sb.size() != 0) begin checks++; failures++; $display("FAIL settle_glitch_leftover got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  // Relock from RUN (no loss), relock again mid-HOLD (restarts the hold), then relock
  // coinciding with a synchronised lock drop in RUN (exactly one loss).
  task automatic test_relock();
    exp_t       e;
    int         b;
    logic [7:0] l0;
    logic [7:0] l1;
    b  = cyc;
    l0 = exp_loss;
    l1 = sat8(exp_loss);
    for (int k = 1; k <= 35; k++) begin
      if (k <= 7)       push_exp(b + k, S_HOLD, 1'b0, l0);
      else if (k == 8)  push_exp(b + k, S_WAIT, 1'b0, l0);
      else if (k <= 16) push_exp(b + k, S_SETTLE, 1'b0, l0);
      else if (k <= 20) push_exp(b + k, S_RUN, 1'b0, l0);
      else if (k <= 24) push_exp(b + k, S_HOLD, 1'b0, l1);
      else if (k == 25) push_exp(b + k, S_WAIT, 1'b0, l1);
      else if (k <= 33) push_exp(b + k, S_SETTLE, 1'b0, l1);
      else              push_exp(b + k, S_RUN, 1'b0, l1);
    end
    relock_req = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k == 1)  relock_req = 1'b0;
      if (k == 3)  relock_req = 1'b1;
      if (k == 4)  relock_req = 1'b0;
      if (k == 18) locked_async = 1'b0;
      if (k == 20) relock_req = 1'b1;
      if (k == 21) begin relock_req = 1'b0; locked_async = 1'b1; end
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st || pll_rst !== (e.st == S_HOLD) || domain_rst !== (e.st != S_RUN) ||
            ready !== (e.st == S_RUN) || fault !== e.fault || loss_count !== e.loss) begin
          failures++;
          $display("FAIL relock cyc=%0d got st=%0d pll_rst=%b domain_rst=%b ready=%b fault=%b loss=%0d exp st=%0d fault=%b loss=%0d",
                   cyc, state_o, pll_rst, domain_rst, ready, fault, loss_count, e.st, e.fault, e.loss);
        end
      end
    end
    if (sb.size() != 0) begin checks++; failures++; $display("FAIL relock_leftover got=%0d exp=0", sb.size()); sb.delete(); end
    exp_loss = l1;
  endtask

  // Lock drop in RUN: HOLD two cycles after the synchroniser sees it; then repeat to saturation.
  task automatic test_lock_loss();
    exp_t       e;
    int         b;
    int         n;
    logic [7:0] l0;
    logic [7:0] want;
    b  = cyc;
    l0 = exp_loss;
    exp_loss = sat8(exp_loss);
    push_exp(b + 1, S_RUN, 1'b0, l0);
    push_exp(b + 2, S_RUN, 1'b0, l0);
    push_exp(b + 3, S_HOLD, 1'b0, exp_loss);
    locked_async = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st || pll_rst !== (e.st == S_HOLD) || domain_rst !== (e.st != S_RUN) ||
            ready !== (e.st == S_RUN) || fault !== e.fault || loss_count !== e.loss) begin
          failures++;
          $display("FAIL lock_loss cyc=%0d got st=%0d pll_rst=%b domain_rst=%b ready=%b fault=%b loss=%0d exp st=%0d fault=%b loss=%0d",
                   cyc, state_o, pll_rst, domain_rst, ready, fault, loss_count, e.st, e.fault, e.loss);
        end
      end
    end
    locked_async = 1'b1;
    for (int i = 0; i < 299; i++) begin
      n = 0;
      while (ready !== 1'b1 && n < 60) begin step(); n++; end
      if (ready !== 1'b1) begin
        checks++; failures++;
        $display("FAIL lock_loss_ready_timeout iter=%0d got ready=%b exp=1", i, ready);
        break;
      end
      locked_async = 1'b0;
      exp_loss = sat8(exp_loss);
      lq.push_back(exp_loss);
      n = 0;
      while (pll_rst !== 1'b1 && n < 10) begin step(); n++; end
      want = lq.pop_front();
      checks++;
      if (pll_rst !== 1'b1 || loss_count !== want) begin
        failures++;
        $display("FAIL lock_loss_count iter=%0d got pll_rst=%b loss=%0d exp pll_rst=1 loss=%0d", i, pll_rst, loss_count, want);
      end
      locked_async = 1'b1;
    end
    checks++;
    if (loss_count !== 8'd255) begin failures++; $display("FAIL lock_loss_saturate got=%0d exp=255", loss_count); end
  endtask

  // Lock lost for good: HOLD/WAIT loop with period RST+TIMEOUT, fault at end of 2nd WAIT.
  // Then a relock with fault set keeps fault and restarts the hold.
  task automatic test_timeout();
    exp_t       e;
    int         b;
    int         n;
    int         r;
    int         per;
    logic [7:0] l0;
    per = RST_CYCLES + LOCK_TIMEOUT;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL timeout_start_ready got=%b exp=1", ready); end
    b  = cyc;
    l0 = exp_loss;
    exp_loss = sat8(exp_loss);
    for (int k = 1; k <= 83; k++) begin
      r = k - 3;
      if (k < 3)                       push_exp(b + k, S_RUN, 1'b0, l0);
      else if ((r % per) < RST_CYCLES) push_exp(b + k, S_HOLD, (r >= MAX_RETRIES * per), exp_loss);
      else                             push_exp(b + k, S_WAIT, (r >= MAX_RETRIES * per), exp_loss);
    end
    locked_async = 1'b0;
    for (int k = 1; k <= 83; k++) begin
      step();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st || pll_rst !== (e.st == S_HOLD) || domain_rst !== (e.st != S_RUN) ||
            ready !== (e.st == S_RUN) || fault !== e.fault || loss_count !== e.loss) begin
          failures++;
          $display("FAIL timeout cyc=%0d got st=%0d pll_rst=%b domain_rst=%b ready=%b fault=%b loss=%0d exp st=%0d fault=%b loss=%0d",
                   cyc, state_o, pll_rst, domain_rst, ready, fault, loss_count, e.st, e.fault, e.loss);
        end
      end
    end
    if (sb.size() != 0) begin checks++; failures++; $display("FAIL timeout_leftover got=%0d exp=0", sb.size()); sb.delete(); end
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    checks++;
    if (state_o !== S_HOLD || fault !== 1'b1 || loss_count !== exp_loss) begin
      failures++;
      $display("FAIL relock_with_fault got st=%0d fault=%b loss=%0d exp st=0 fault=1 loss=%0d", state_o, fault, loss_count, exp_loss);
    end
    repeat (RST_CYCLES - 1) step();
    checks++;
    if (state_o !== S_HOLD) begin failures++; $display("FAIL relock_hold_len got st=%0d exp=0", state_o); end
    step();
    checks++;
    if (state_o !== S_WAIT || fault !== 1'b1) begin
      failures++;
      $display("FAIL relock_to_wait got st=%0d fault=%b exp st=1 fault=1", state_o, fault);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    step();
    checks++; if (state_o !== S_HOLD) begin failures++; $display("FAIL midrst_state got=%0d exp=0", state_o); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL midrst_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (domain_rst !== 1'b1) begin failures++; $display("FAIL midrst_domain_rst got=%b exp=1", domain_rst); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL midrst_fault got=%b exp=0", fault); end
    checks++; if (loss_count !== 8'd0) begin failures++; $display("FAIL midrst_loss got=%0d exp=0", loss_count); end
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    exp_loss = 8'd0;
    test_reset();
    test_power_up();
    test_settle_glitch();
    test_relock();
    test_lock_loss();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
